// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32I/E core:
// opcode, funct3/funct7 and EBREAK encodings, plus the FSM state type.
package rv_pkg;

   localparam logic [6:0] OP_IMM    = 7'h13;
   localparam logic [6:0] OP_REG    = 7'h33;
   localparam logic [6:0] OP_LUI    = 7'h37;
   localparam logic [6:0] OP_AUIPC  = 7'h17;
   localparam logic [6:0] OP_JAL    = 7'h6F;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_SYSTEM = 7'h73;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [6:0] F7_ADD = 7'h00;
   localparam logic [6:0] F7_SUB = 7'h20;

   localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

   typedef enum logic [1:0] {
      RESET,
      FETCH,
      EXEC,
      HALT
   } state_t;

endpackage

// File: rtl/rv_regfile.sv
// NREG x XLEN register file: two combinational read ports, one write port.
// Ports: clk; raddr1/raddr2 -> rdata1/rdata2; we/waddr/wdata. x0 reads 0.
module rv_regfile #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   localparam int AW = $clog2(NREG)
) (
   input  logic            clk,
   input  logic [AW-1:0]   raddr1,
   input  logic [AW-1:0]   raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2,
   input  logic            we,
   input  logic [AW-1:0]   waddr,
   input  logic [XLEN-1:0] wdata
);

   logic [XLEN-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (we && waddr != '0)
         mem[waddr] <= wdata;
   end

   assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
   assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule

// File: rtl/rv_multicycle_core.sv
// Multi-cycle RV32I/RV32E subset core: FETCH/EXEC FSM, decode, ALU, commit trace.
// Ports: clk, rst (async low); imem_req/addr/rdata/valid; pc; commit_*; halted, error.
module rv_multicycle_core
   import rv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   input  logic            imem_valid,
   output logic [XLEN-1:0] pc,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [4:0]      commit_rd,
   output logic [XLEN-1:0] commit_data,
   output logic            halted,
   output logic            error
);

   localparam int AW = $clog2(NREG);

   state_t state, state_nx;
   logic [31:0] ir;

   logic [6:0] opc;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = ir[6:0];
   assign rd  = ir[11:7];
   assign f3  = ir[14:12];
   assign rs1 = ir[19:15];
   assign rs2 = ir[24:20];
   assign f7  = ir[31:25];

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] imm_j;

   assign imm_i = {{(XLEN-12){ir[31]}}, ir[31:20]};
   assign imm_u = XLEN'({ir[31:12], 12'b0});
   assign imm_j = {{(XLEN-20){ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};

   logic [XLEN-1:0] src1;
   logic [XLEN-1:0] src2;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] result;
   logic [XLEN-1:0] target;

   logic legal;
   logic use_rs1;
   logic use_rs2;
   logic use_rd;
   logic is_jump;
   logic is_ebreak;
   logic bad_reg;
   logic misalign;
   logic fault;
   logic wr_en;

   assign pc_plus4 = pc + XLEN'(4);

   rv_regfile #(
      .XLEN (XLEN),
      .NREG (NREG)
   ) u_rf (
      .clk    (clk),
      .raddr1 (rs1[AW-1:0]),
      .raddr2 (rs2[AW-1:0]),
      .rdata1 (src1),
      .rdata2 (src2),
      .we     (wr_en),
      .waddr  (rd[AW-1:0]),
      .wdata  (result)
   );

   always_comb begin
      legal     = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      use_rd    = 1'b0;
      is_jump   = 1'b0;
      is_ebreak = 1'b0;
      result    = '0;
      target    = pc_plus4;
      unique case (1'b1)
         (opc == OP_IMM && f3 == F3_ADD): begin
            legal   = 1'b1;
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            result  = src1 + imm_i;
         end
         (opc == OP_REG && f3 == F3_ADD && f7 == F7_ADD): begin
            legal   = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            result  = src1 + src2;
         end
         (opc == OP_REG && f3 == F3_ADD && f7 == F7_SUB): begin
            legal   = 1'b1;
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            use_rd  = 1'b1;
            result  = src1 - src2;
         end
         (opc == OP_LUI): begin
            legal  = 1'b1;
            use_rd = 1'b1;
            result = imm_u;
         end
         (opc == OP_AUIPC): begin
            legal  = 1'b1;
            use_rd = 1'b1;
            result = pc + imm_u;
         end
         (opc == OP_JAL): begin
            legal   = 1'b1;
            use_rd  = 1'b1;
            is_jump = 1'b1;
            result  = pc_plus4;
            target  = pc + imm_j;
         end
         (opc == OP_JALR && f3 == F3_ADD): begin
            legal   = 1'b1;
            use_rs1 = 1'b1;
            use_rd  = 1'b1;
            is_jump = 1'b1;
            result  = pc_plus4;
            target  = (src1 + imm_i) & ~XLEN'(1);
         end
         (opc == OP_SYSTEM && ir == EBREAK_INSN): begin
            legal     = 1'b1;
            is_ebreak = 1'b1;
         end
         default: ;
      endcase
   end

   // RV32E: any referenced register outside the implemented file is a fault.
   assign bad_reg = (use_rs1 && int'(rs1) >= NREG)
                 || (use_rs2 && int'(rs2) >= NREG)
                 || (use_rd  && int'(rd)  >= NREG);

   assign misalign = is_jump && target[1];
   assign fault    = !legal || bad_reg || misalign;
   assign wr_en    = (state == EXEC) && !fault && use_rd && (rd != 5'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= RESET;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         RESET: state_nx = FETCH;
         FETCH: if (imem_valid) state_nx = EXEC;
         EXEC:  state_nx = (fault || is_ebreak) ? HALT : FETCH;
         HALT:  state_nx = HALT;
         default: state_nx = RESET;
      endcase
   end

   always_comb begin
      imem_req  = (state == FETCH);
      halted    = (state == HALT);
      imem_addr = imem_req ? pc : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc           <= RESET_PC;
         ir           <= '0;
         commit_valid <= 1'b0;
         commit_pc    <= '0;
         commit_rd    <= '0;
         commit_data  <= '0;
         error        <= 1'b0;
      end else begin
         commit_valid <= 1'b0;
         if (state == FETCH && imem_valid)
            ir <= imem_rdata;
         if (state == EXEC) begin
            if (fault) begin
               error <= 1'b1;
            end else begin
               pc           <= target;
               commit_valid <= 1'b1;
               commit_pc    <= pc;
               commit_rd    <= wr_en ? rd : 5'd0;
               commit_data  <= wr_en ? result : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_rv_multicycle_core.sv
// Randomised bench for rv_multicycle_core against an architectural model.
// Commits are scoreboarded; an RV32E instance covers the register-range fault.
module tb_rv_multicycle_core;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   localparam int K_ADDI  = 0;
   localparam int K_ADD   = 1;
   localparam int K_SUB   = 2;
   localparam int K_LUI   = 3;
   localparam int K_AUIPC = 4;
   localparam int K_JAL   = 5;
   localparam int K_JALR  = 6;
   localparam int K_EBRK  = 7;
   localparam int K_BAD   = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic [31:0] pc;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic [4:0]  commit_rd;
   logic [31:0] commit_data;
   logic        halted;
   logic        error;

   logic        rst_e;
   logic        imem_req_e;
   logic [31:0] imem_addr_e;
   logic [31:0] imem_rdata_e;
   logic        imem_valid_e;
   logic [31:0] pc_e;
   logic        commit_valid_e;
   logic [31:0] commit_pc_e;
   logic [4:0]  commit_rd_e;
   logic [31:0] commit_data_e;
   logic        halted_e;
   logic        error_e;

   rv_multicycle_core #(.XLEN(32), .NREG(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .pc(pc), .commit_valid(commit_valid), .commit_pc(commit_pc),
      .commit_rd(commit_rd), .commit_data(commit_data),
      .halted(halted), .error(error)
   );

   rv_multicycle_core #(.XLEN(32), .NREG(16), .RESET_PC(RST_PC)) dut_e (
      .clk(clk), .rst(rst_e),
      .imem_req(imem_req_e), .imem_addr(imem_addr_e),
      .imem_rdata(imem_rdata_e), .imem_valid(imem_valid_e),
      .pc(pc_e), .commit_valid(commit_valid_e), .commit_pc(commit_pc_e),
      .commit_rd(commit_rd_e), .commit_data(commit_data_e),
      .halted(halted_e), .error(error_e)
   );

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t q[$];

   logic [31:0] mreg [32];
   bit          known [32];
   logic [31:0] mpc;
   logic [31:0] bad_tab [5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %h required %h", nm, act, req);
      end
   endtask

   function automatic logic [31:0] enc_i(logic [31:0] imm, int rs1, int rd, logic [6:0] op);
      return {imm[11:0], 5'(rs1), 3'b000, 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_r(logic [6:0] f7, int rs2, int rs1, int rd);
      return {f7, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
   endfunction

   function automatic logic [31:0] enc_u(logic [31:0] imm, int rd, logic [6:0] op);
      return {imm[19:0], 5'(rd), op};
   endfunction

   function automatic logic [31:0] enc_j(logic [31:0] off, int rd);
      return {off[20], off[10:1], off[11], off[19:12], 5'(rd), 7'h6F};
   endfunction

   function automatic void model_reset();
      mpc = RST_PC;
      for (int i = 0; i < 32; i++) known[i] = (i == 0);
      mreg[0] = '0;
   endfunction

   function automatic int pick();
      int r;
      for (int i = 0; i < 8; i++) begin
         r = int'($urandom_range(0, 31));
         if (known[r]) return r;
      end
      return 0;
   endfunction

   // Called at a negedge; leaves the core freshly out of reset at a negedge.
   task automatic do_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'd0);
      chk("rst_pc", pc, RST_PC);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_commit", 32'(commit_valid), 32'd0);
      imem_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
   endtask

   task automatic fetch_one(input int kind, input int rd, input int rs1, input int rs2,
                            input logic [31:0] imm, input int waits, input bit rwait);
      logic [31:0] ins, res, npc, a, b;
      bit flt, hlt, wrote;
      int t;
      exp_t e;
      t = 0;
      while (imem_req !== 1'b1 && t < 10) begin
         @(negedge clk);
         t++;
      end
      if (imem_req !== 1'b1) begin
         chk("fetch_timeout", 32'(imem_req), 32'd1);
         do_reset();
         return;
      end
      chk("imem_addr", imem_addr, mpc);
      a = mreg[rs1];
      b = mreg[rs2];
      npc = mpc + 4;
      res = '0;
      flt = 1'b0;
      hlt = 1'b0;
      case (kind)
         K_ADDI: begin ins = enc_i(imm, rs1, rd, 7'h13); res = a + imm; end
         K_ADD: begin ins = enc_r(7'h00, rs2, rs1, rd); res = a + b; end
         K_SUB: begin ins = enc_r(7'h20, rs2, rs1, rd); res = a - b; end
         K_LUI: begin ins = enc_u(imm, rd, 7'h37); res = imm << 12; end
         K_AUIPC: begin ins = enc_u(imm, rd, 7'h17); res = mpc + (imm << 12); end
         K_JAL: begin
            ins = enc_j(imm, rd);
            res = mpc + 4;
            npc = mpc + imm;
            flt = npc[1];
         end
         K_JALR: begin
            ins = enc_i(imm, rs1, rd, 7'h67);
            res = mpc + 4;
            npc = (a + imm) & 32'hFFFF_FFFE;
            flt = npc[1];
         end
         K_EBRK: begin ins = 32'h0010_0073; hlt = 1'b1; end
         default: begin ins = bad_tab[int'(imm % 5)]; flt = 1'b1; end
      endcase
      hlt = hlt | flt;
      wrote = !flt && kind != K_EBRK && rd != 0;
      imem_valid = 1'b0;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, mpc);
      end
      if (rwait) begin
         do_reset();
         return;
      end
      imem_valid = 1'b1;
      imem_rdata = ins;
      if (!flt) begin
         e.pc = mpc;
         e.rd = wrote ? 5'(rd) : 5'd0;
         e.data = wrote ? res : 32'd0;
         q.push_back(e);
      end
      @(negedge clk);
      chk("no_early_commit", 32'(commit_valid), 32'd0);
      imem_valid = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      imem_valid = 1'b0;
      chk("commit_pulse", 32'(commit_valid), 32'(!flt));
      chk("halted", 32'(halted), 32'(hlt));
      chk("error", 32'(error), 32'(flt));
      if (!flt) begin
         if (wrote) begin
            mreg[rd] = res;
            known[rd] = 1'b1;
         end
         mpc = npc;
      end
      if (hlt) begin
         for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_pc", pc, mpc);
         end
         do_reset();
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (commit_valid === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_commit", 32'd1, 32'd0);
         end else begin
            e = q.pop_front();
            chk("commit_pc", commit_pc, e.pc);
            chk("commit_rd", 32'(commit_rd), 32'(e.rd));
            chk("commit_data", commit_data, e.data);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int kind, r, rd, n;
      logic [31:0] imm;
      int v;
      bad_tab = '{32'h0000_2083, 32'h0010_9093, 32'h0220_81B3,
                  32'h0000_0073, 32'h0020_C1B3};
      rst = 1'b0;
      rst_e = 1'b0;
      imem_valid = 1'b0;
      imem_rdata = '0;
      imem_valid_e = 1'b0;
      imem_rdata_e = '0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_pc", pc, RST_PC);
      chk("reset_req", 32'(imem_req), 32'd0);
      chk("reset_commit", 32'(commit_valid), 32'd0);
      chk("reset_halted", 32'(halted), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("first_fetch_req", 32'(imem_req), 32'd1);

      fetch_one(K_ADDI, 1, 0, 0, 32'd5, 0, 0);
      fetch_one(K_ADDI, 1, 0, 0, 32'hFFFF_FFFF, 0, 0);
      fetch_one(K_ADDI, 2, 1, 0, 32'd2, 0, 0);
      fetch_one(K_SUB, 3, 2, 1, 32'd0, 0, 0);
      do_reset();
      fetch_one(K_LUI, 5, 0, 0, 32'h12345, 0, 0);
      fetch_one(K_AUIPC, 6, 0, 0, 32'd1, 0, 0);
      do_reset();
      fetch_one(K_JAL, 1, 0, 0, 32'd8, 0, 0);
      fetch_one(K_LUI, 7, 0, 0, 32'h80000, 0, 0);
      fetch_one(K_ADDI, 7, 7, 0, 32'h101, 0, 0);
      fetch_one(K_JALR, 0, 7, 0, 32'd0, 0, 0);
      fetch_one(K_LUI, 7, 0, 0, 32'h80000, 0, 0);
      fetch_one(K_ADDI, 7, 7, 0, 32'h102, 0, 0);
      fetch_one(K_JALR, 0, 7, 0, 32'd0, 0, 0);
      fetch_one(K_ADDI, 1, 0, 0, 32'd1, 3, 0);
      fetch_one(K_ADDI, 2, 0, 0, 32'd9, 2, 1);
      fetch_one(K_EBRK, 0, 0, 0, 32'd0, 0, 0);
      fetch_one(K_BAD, 3, 0, 0, 32'd2, 0, 0);

      for (int it = 0; it < 400; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 20) kind = K_ADDI;
         else if (r < 35) kind = K_ADD;
         else if (r < 50) kind = K_SUB;
         else if (r < 60) kind = K_LUI;
         else if (r < 68) kind = K_AUIPC;
         else if (r < 78) kind = K_JAL;
         else if (r < 85) kind = K_JALR;
         else if (r < 88) kind = K_EBRK;
         else if (r < 91) kind = K_BAD;
         else kind = K_ADDI;
         rd = (kind == K_EBRK) ? 0 : int'($urandom_range(0, 31));
         case (kind)
            K_LUI, K_AUIPC: imm = 32'($urandom_range(0, 20'hFFFFF));
            K_JAL: begin
               v = (int'($urandom_range(0, 127)) - 64) * 4;
               if ($urandom_range(0, 7) == 0) v += 2;
               imm = 32'(v);
            end
            K_BAD: imm = 32'($urandom_range(0, 4));
            default: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
         endcase
         n = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
         fetch_one(kind, rd, pick(), pick(), imm, n,
                   n > 0 && $urandom_range(0, 19) == 0);
      end

      repeat (4) @(negedge clk);
      chk("queue_empty", 32'(q.size()), 32'd0);

      chk("e_reset_halted", 32'(halted_e), 32'd0);
      chk("e_reset_req", 32'(imem_req_e), 32'd0);
      rst_e = 1'b1;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (commit_valid_e === 1'b1) begin
            n++;
            chk("e_commit_pc", commit_pc_e, RST_PC);
            chk("e_commit_rd", 32'(commit_rd_e), 32'd3);
            chk("e_commit_data", commit_data_e, 32'd7);
         end
         imem_valid_e = imem_req_e;
         imem_rdata_e = (imem_addr_e == RST_PC) ? enc_i(32'd7, 0, 3, 7'h13)
                                                : enc_i(32'd1, 0, 20, 7'h13);
      end
      chk("e_commit_count", 32'(n), 32'd1);
      chk("e_halted", 32'(halted_e), 32'd1);
      chk("e_error", 32'(error_e), 32'd1);
      chk("e_fault_pc", pc_e, RST_PC + 4);
      chk("e_halt_req", 32'(imem_req_e), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_multicycle_core.md
Name: rv_multicycle_core

Overview:
- Parametrised multi-cycle RV32I-subset execution core; successor to the single-cycle addi datapath.
- Owns PC, decode, ALU and register file, and fetches instructions itself over a req/valid instruction-memory handshake.
- Adds ADD/SUB/LUI/AUIPC/JAL/JALR/EBREAK, an RV32E mode, a commit trace port, and a halt/error state.

Parameters:
- XLEN, 32, datapath width; only 32 is legal.
- NREG, 32, architectural register count; 32 (RV32I) or 16 (RV32E).
- RESET_PC, 32'h8000_0000, PC value loaded at reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request; held high until accepted
- imem_addr  out  XLEN  fetch address, equal to pc while imem_req is high
- imem_rdata  in  32  instruction word, sampled when imem_valid is high
- imem_valid  in  1  instruction-return strobe; ignored unless state is FETCH
- pc  out  XLEN  current PC
- commit_valid  out  1  one-cycle pulse per retired instruction
- commit_pc  out  XLEN  PC of the retired instruction
- commit_rd  out  5  destination register index; 0 when there is no write
- commit_data  out  XLEN  value written to rd; 0 when there is no write
- halted  out  1  high in state HALT
- error  out  1  high in HALT when entered via a fault

Behaviour:
- Reset (rst low, asynchronous):
  - state=RESET, pc=RESET_PC.
  - All outputs low/zero, except pc.
  - Register contents are undefined, except x0, which always reads 0.
  - Reset asserted mid-fetch drops imem_req immediately; no commit occurs.
- FSM states:
  - RESET: one cycle after rst deasserts, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc. When imem_valid=1, latch imem_rdata into ir and go to EXEC. With zero wait states, FETCH lasts 1 cycle.
  - EXEC: decode ir, read rs1/rs2 combinationally, compute, then on the clock edge leaving EXEC:
    - write rd;
    - update pc;
    - pulse commit_valid;
    - go to FETCH, or to HALT on EBREAK or fault.
  - HALT: terminal. imem_req=0, pc frozen. Only reset exits.
- Throughput: 2 cycles per instruction at zero memory wait; each wait cycle adds 1.
- Supported instructions (all others fault):
  - ADDI: rd = rs1 + sext(imm[11:0]).
  - ADD / SUB: rd = rs1 +/- rs2 (funct7 0x00 / 0x20, funct3 0).
  - LUI: rd = {imm[31:12], 12'b0}.
  - AUIPC: rd = pc + {imm[31:12], 12'b0}.
  - JAL: rd = pc+4; pc = pc + sext(J-imm).
  - JALR: rd = pc+4; pc = (rs1 + sext(I-imm)) & ~1.
  - EBREAK (32'h0010_0073): commit with rd=0, go to HALT, error=0.
- Arithmetic: all results are modulo 2^XLEN with no overflow detection. Non-jump instructions set pc = pc+4, which wraps at 2^XLEN.
- x0: writes are discarded; commit_rd=0 and commit_data=0 for any instruction whose rd is x0.
- Faults (HALT, error=1):
  - unsupported encoding;
  - NREG=16 with any used rs1/rs2/rd index >= 16;
  - jump target with bit1 set (misaligned).
- On a fault, no register write happens, pc keeps the faulting address, and commit_valid stays 0.
- Read-after-write: an instruction reads values written by the previous commit; no bypass is needed because writes complete before the next EXEC.
- imem_valid asserted outside FETCH has no effect.

Decomposition:
- Package rv_pkg:
  - opcode constants (OP_IMM, OP, LUI, AUIPC, JAL, JALR, SYSTEM);
  - funct3/funct7 constants;
  - EBREAK encoding;
  - state enum {RESET, FETCH, EXEC, HALT}.
- Sub-module rv_regfile (NREG x XLEN):
  - 2 combinational read ports, 1 synchronous write port;
  - x0 hardwired to 0;
  - no reset on storage.
- Decode, ALU and FSM live in the top module.

Test Plan:
- Reset, then zero-wait memory returning ADDI x1,x0,5: imem_addr=0x8000_0000; commit at cycle 3 with rd=1, data=5; next imem_addr=0x8000_0004.
- Program: ADDI x1,x0,-1; ADDI x2,x1,2; SUB x3,x2,x1
  - Commit data 0xFFFF_FFFF, 0x0000_0001, 0x0000_0002.
- LUI x5,0x12345; AUIPC x6,1 at pc 0x8000_0004
  - x5=0x1234_5000; x6=0x8000_1004.
- JAL x1,+8 at 0x8000_0000: rd=0x8000_0004, next fetch 0x8000_0008.
- JALR x0,0(x7) with x7=0x8000_0101: next fetch 0x8000_0100, commit_rd=0.
- JALR with x7=0x8000_0102: misaligned fault.
- NREG=16 with ADDI x20,x0,1: fault, halted=1, error=1, no commit.
- EBREAK: commit pulse, halted=1, error=0, imem_req stays 0.
- 3 wait cycles on imem_valid: imem_addr stays stable throughout.
- rst pulse during a wait: imem_req drops asynchronously; fetch restarts at 0x8000_0000.
